// File: rtl/rotl_iter.sv
// Iterative rotate-left unit: one bit per cycle, or four per cycle when
// ROTL_ITER_FAST_EN is defined. A done pulse marks a new result on dout.
module rotl_iter #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROT  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic [AMT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_rot1;
    logic [WIDTH-1:0] w_next_work;
    logic [AMT_W-1:0] w_next_cnt;

    assign w_rot1 = {r_work[WIDTH-2:0], r_work[WIDTH-1]};

`ifdef ROTL_ITER_FAST_EN
    logic [WIDTH-1:0] w_rot4;
    logic             w_big_step;

    assign w_rot4     = {r_work[WIDTH-5:0], r_work[WIDTH-1:WIDTH-4]};
    assign w_big_step = (r_cnt >= AMT_W'(4));

    // Take a 4-bit step while at least four positions remain, else a single bit.
    always_comb begin
        w_next_work = w_rot1;
        w_next_cnt  = r_cnt - AMT_W'(1);
        if (w_big_step) begin
            w_next_work = w_rot4;
            w_next_cnt  = r_cnt - AMT_W'(4);
        end else begin
            w_next_work = w_rot1;
            w_next_cnt  = r_cnt - AMT_W'(1);
        end
    end
`else
    assign w_next_work = w_rot1;
    assign w_next_cnt  = r_cnt - AMT_W'(1);
`endif

    // Control FSM with registered busy/done and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_work  <= {WIDTH{1'b0}};
            r_cnt   <= {AMT_W{1'b0}};
            r_dout  <= {WIDTH{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_work  <= din;
                        r_cnt   <= amt;
                        r_busy  <= 1'b1;
                        r_state <= ST_ROT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_ROT: begin
                    if (r_cnt == {AMT_W{1'b0}}) begin
                        r_dout  <= r_work;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_work  <= w_next_work;
                        r_cnt   <= w_next_cnt;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= ST_ROT;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dout = r_dout;

endmodule

// File: doc/rotl_iter.md
# rotl_iter

Iterative rotate-left unit for the SHA-256 datapath, the inverse companion to the existing right-rotate block. It accepts a word and a run-time rotate amount on a start strobe and rotates one bit per cycle, or four per cycle when fast mode is compiled in. It signals completion with a one-cycle done pulse and holds the result until the next operation. Used to undo or cross-check right rotations in the message schedule and compression verification paths.

## Interface
- WIDTH, 32, data word width in bits
- AMT_W, 5, rotate-amount width; amounts range 0..2^AMT_W-1, and WIDTH must be ≥ 2^AMT_W
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request strobe; sampled only when not busy
- amt  input  AMT_W  rotate-left amount, captured with start
- din  input  WIDTH  word to rotate, captured with start
- busy  output  1  high while a rotation is in progress
- done  output  1  one-cycle pulse; dout is valid from this cycle onward
- dout  output  WIDTH  result register; holds its value until the next done

## Operation
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Internal state: a working register `work`, a counter `cnt` (AMT_W bits) and a result register driving dout.
- FSM states:
  - IDLE: busy=0, done=0. If start=1, then work←din, cnt←amt, and the FSM goes to ROT.
  - ROT: busy=1.
    - If cnt≠0: work←{work[WIDTH-2:0], work[WIDTH-1]} and cnt←cnt-1.
    - If cnt=0: dout←work and the FSM goes to DONE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - If start=1 in DONE, it is accepted exactly as in IDLE, and the FSM goes to ROT.
    - Otherwise the FSM goes to IDLE.
- In ROT, start, amt and din are ignored. There is no queueing.
- Arithmetic: a pure rotation. No bits are lost; popcount(dout)=popcount(din).
- amt=0: there is one ROT cycle with cnt=0, and dout=din.
- Reset values: FSM=IDLE, busy=0, done=0, dout=0, work=0, cnt=0.
- Reset mid-operation: the operation is abandoned. dout reads 0, and no done pulse is issued for the abandoned request.

## Timing
- Start is accepted at edge E0.
- Base latency: done is high in the cycle following edge E(amt+1), i.e. amt+1 cycles after acceptance.
- busy is high from the cycle after E0 through the cycle where cnt=0, which is amt+1 cycles.
- dout updates at the same edge that raises done.
- Back-to-back operation: start asserted during the DONE cycle is accepted at that cycle's edge, giving amt+2 cycles per operation.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro ROTL_ITER_FAST_EN.
- Defined: in ROT, when cnt≥4 the unit rotates left by 4 and decrements cnt by 4. When 0<cnt<4 it rotates by 1, as in the base mode. Latency is floor(amt/4)+(amt mod 4)+1 cycles. Results are identical to the base mode.
- Undefined: one bit per cycle only, with latency amt+1. No 4-step logic is synthesized.

## Test plan
- Basic rotate: din=0x0000000F, amt=8 -> dout=0x00000F00. done arrives 9 cycles after start (fast mode: 3 cycles).
- Wrap-around: din=0x80000001, amt=1 -> dout=0x00000003. din=0x00000001, amt=31 -> dout=0x80000000, latency 32 (fast mode: 11).
- Zero amount: din=0xDEADBEEF, amt=0 -> dout=0xDEADBEEF, done 1 cycle after start, busy high for exactly 1 cycle.
- Ignore while busy: start din=0x12345678, amt=4, then re-pulse start with din=0xFFFFFFFF, amt=1 two cycles later.
  - Required: a single done, with dout=0x23456781.
  - Back-to-back: start held during DONE with din=0x1, amt=2 -> the next done gives dout=0x4.
- Reset mid-operation: start amt=20, assert rst at cycle 5 -> busy=0, done=0, dout=0 immediately. No done pulse follows. A fresh start afterwards completes normally.
- Inverse check: pair with the right-rotate block. For random din and amt, rotr(rotl_iter(din, amt), amt) must equal din over 1000 vectors, in both macro settings.
